// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply / restoring divide unit driving HI/LO
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             mul0_div1_sel,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             done,
   output logic             stall_req,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [2*WIDTH-1:0] acc, acc_nxt, prod;
   logic [WIDTH-1:0] mcand, mag_a, mag_b, quot, rem;
   logic [WIDTH:0] sum, rem_sh;
   logic [CW-1:0] cnt;
   logic op_div, neg_lo, neg_hi, sign_a, sign_b, launch, last;
   always_comb begin
      sign_a    = is_signed & in_a[WIDTH-1];
      sign_b    = is_signed & in_b[WIDTH-1];
      mag_a     = sign_a ? -in_a : in_a;
      mag_b     = sign_b ? -in_b : in_b;
      launch    = (state == IDLE) & start & ~abort;
      last      = (state == BUSY) & (cnt == CW'(1));
      sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
      rem_sh    = acc[2*WIDTH-1:WIDTH-1];
      acc_nxt   = op_div ? (rem_sh >= {1'b0, mcand} ? {rem_sh[WIDTH-1:0] - mcand, acc[WIDTH-2:0], 1'b1}
                                                    : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0})
                         : (acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
      prod      = neg_lo ? -acc_nxt : acc_nxt;
      quot      = neg_lo ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
      rem       = neg_hi ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
      state_nxt = abort            ? IDLE :
                  state == IDLE    ? (launch ? ((mul0_div1_sel && in_b == '0) ? DONE : BUSY) : IDLE) :
                  state == BUSY    ? (last ? DONE : BUSY) : IDLE;
      busy      = state == BUSY;
      done      = (state == DONE) & ~abort;
      stall_req = (start & (state == IDLE)) | (state == BUSY);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         mcand       <= '0;
         cnt         <= '0;
         op_div      <= 1'b0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         div_by_zero <= 1'b0;
         out_hi      <= '0;
         out_lo      <= '0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            mcand  <= mul0_div1_sel ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, mul0_div1_sel ? mag_a : mag_b};
            cnt    <= CW'(WIDTH);
            op_div <= mul0_div1_sel;
            neg_lo <= sign_a ^ sign_b;
            neg_hi <= sign_a;
            if (mul0_div1_sel && in_b == '0) begin
               out_lo      <= '1;
               out_hi      <= in_a;
               div_by_zero <= 1'b1;
            end
         end else if (busy && !abort) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (last) begin
               out_hi <= op_div ? rem : prod[2*WIDTH-1:WIDTH];
               out_lo <= op_div ? quot : prod[WIDTH-1:0];
               if (op_div) div_by_zero <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: randomized check of muldiv_iter against an arithmetic reference model
module tb_muldiv_iter;
   logic clk = 0, rst = 1, start = 0, abort = 0, sel = 0, sgn = 0;
   logic [31:0] in_a = 0, in_b = 0;
   logic busy, done, stall_req, div_by_zero;
   logic [31:0] out_hi, out_lo;
   int checks = 0, errors = 0;
   logic [31:0] exp_hi = 0, exp_lo = 0;
   logic exp_dbz = 0;

   muldiv_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mul0_div1_sel(sel),
      .is_signed(sgn), .in_a(in_a), .in_b(in_b), .busy(busy), .done(done),
      .stall_req(stall_req), .div_by_zero(div_by_zero), .out_hi(out_hi), .out_lo(out_lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      if (!d) begin
         if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
         end
         ua = a;
         ub = b;
         return ua * ub;
      end
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = a;
         sb = b;
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic launch(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      sel = d; sgn = s; in_a = a; in_b = b; start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   task automatic run_op(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b, input bit pulse);
      logic [63:0] r;
      int cyc, nb;
      bit bad_stall, bad_hold;
      r = model(d, s, a, b);
      launch(d, s, a, b);
      nb = 0; bad_stall = 0; bad_hold = 0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         if (done) break;
         if (busy) nb++;
         if (busy && !stall_req) bad_stall = 1;
         if (busy && (out_hi !== exp_hi || out_lo !== exp_lo)) bad_hold = 1;
         start = pulse && cyc == 5;
         if (pulse && cyc == 5) begin in_a = 32'h7; in_b = 32'h3; sel = ~d; end
         @(posedge clk);
         #1 start = 0;
      end
      chk("latency", cyc, (d && b == 0) ? 1 : 33);
      chk("busy_cycles", nb, (d && b == 0) ? 0 : 32);
      chk("stall_in_busy", bad_stall, 0);
      chk("hold_in_busy", bad_hold, 0);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      if (d) exp_dbz = (b == 0);
      chk("hi", out_hi, exp_hi);
      chk("lo", out_lo, exp_lo);
      chk("dbz", div_by_zero, exp_dbz);
      @(posedge clk);
      #1;
      chk("done_pulse", {busy, done}, 0);
   endtask

   initial begin
      int cyc;
      bit saw_done;
      #12;
      chk("rst_outs", {busy, done, stall_req, div_by_zero, out_hi, out_lo}, 0);
      @(negedge clk) rst = 0;
      run_op(0, 1, 32'hFFFF_FFFD, 32'd5, 0);
      chk("mult_m3x5", {out_hi, out_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      chk("multu_max", {out_hi, out_lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0);
      chk("div_m7d2", {out_hi, out_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      chk("div_wrap", {out_hi, out_lo}, 64'h0000_0000_8000_0000);
      run_op(1, 0, 32'h1234, 32'd0, 0);
      chk("divu_zero", {div_by_zero, out_hi, out_lo}, {1'b1, 64'h0000_1234_FFFF_FFFF});
      run_op(0, 1, 32'd3, 32'd4, 0);
      chk("dbz_sticky_mul", div_by_zero, 1);
      run_op(1, 1, 32'd9, 32'd3, 0);
      chk("dbz_cleared", div_by_zero, 0);
      for (int i = 0; i < 30; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 0;
            1: b = $urandom_range(1, 15);
            2: a = 32'h8000_0000;
            default: ;
         endcase
         run_op($urandom_range(0, 1), $urandom_range(0, 1), a, b, 0);
      end
      run_op(1, 0, 32'd100, 32'd7, 0);
      chk("divu_100_7", {div_by_zero, out_hi, out_lo}, {1'b0, 64'h0000_0002_0000_000E});
      launch(1, 0, 32'd1000, 32'd3);
      for (cyc = 1; cyc < 10; cyc++) @(posedge clk);
      #1 abort = 1;
      chk("abort_busy_before", busy, 1);
      @(posedge clk);
      #1 abort = 0;
      chk("abort_idle", {busy, done}, 0);
      saw_done = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk);
         #1 if (done || busy) saw_done = 1;
      end
      chk("abort_no_done", saw_done, 0);
      chk("abort_hold", {out_hi, out_lo}, 64'h0000_0002_0000_000E);
      launch(1, 0, 32'd1000, 32'd3);
      for (cyc = 1; cyc < 20; cyc++) @(posedge clk);
      #1 rst = 1;
      #1;
      chk("rst_mid_op", {busy, done, stall_req, div_by_zero, out_hi, out_lo}, 0);
      @(negedge clk) rst = 0;
      exp_hi = 0; exp_lo = 0; exp_dbz = 0;
      run_op(0, 0, 32'd6, 32'd7, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
